// File: rtl/keypad_pkg.sv
// Shared types and key map for the keypad entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} deb_state_e;
  typedef enum logic [1:0] {ScanNone, ScanOne, ScanMulti} scan_res_e;

  // Pmod KYPD layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row synchronizer, per-scan classification and press/release debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 2000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_hit,
  output logic [3:0] key_hit_code
);

  localparam int unsigned DwellW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int unsigned DebW   = $clog2(DEBOUNCE_SCANS + 1);

  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        row_s1_q, row_s2_q;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_code_q, acc_code_d;
  deb_state_e        state_q, state_d;
  logic [DebW-1:0]   deb_q, deb_d, deb_inc;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        key_code_q;
  logic              key_valid_q;

  logic       sample, scan_done;
  logic [3:0] lows, col_code, scan_code;
  logic [2:0] col_cnt, tot;
  logic [1:0] sum_cnt;
  logic       found;
  scan_res_e  res;

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign deb_inc   = deb_q + DebW'(1);

  always_comb begin
    sample    = (dwell_q == DwellW'(SCAN_DIV));
    scan_done = sample && (col_idx_q == 2'd3);
    lows      = ~row_s2_q;
    col_cnt   = 3'd0;
    col_code  = 4'h0;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lows[i]) begin
        col_cnt = col_cnt + 3'd1;
        if (!found) begin
          col_code = key_map(2'(i), col_idx_q);
          found    = 1'b1;
        end
      end
    end
    tot       = {1'b0, acc_cnt_q} + col_cnt;
    sum_cnt   = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    scan_code = (acc_cnt_q == 2'd0) ? col_code : acc_code_q;
    case (sum_cnt)
      2'd0:    res = ScanNone;
      2'd1:    res = ScanOne;
      default: res = ScanMulti;
    endcase

    dwell_d    = sample ? '0 : dwell_q + DwellW'(1);
    col_idx_d  = sample ? col_idx_q + 2'd1 : col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_cnt_d  = scan_done ? 2'd0 : sum_cnt;
      acc_code_d = scan_done ? 4'h0 : scan_code;
    end
  end

  // Debounce decisions happen only once per full scan.
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    cand_d       = cand_q;
    key_hit      = 1'b0;
    key_hit_code = cand_q;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (res == ScanOne) begin
            cand_d = scan_code;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d      = StHeld;
              key_hit      = 1'b1;
              key_hit_code = scan_code;
            end else begin
              state_d = StPressWait;
              deb_d   = DebW'(1);
            end
          end
        end
        StPressWait: begin
          if (res == ScanOne && scan_code == cand_q) begin
            if (deb_inc >= DebW'(DEBOUNCE_SCANS)) begin
              state_d = StHeld;
              deb_d   = '0;
              key_hit = 1'b1;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d = StIdle;
            deb_d   = '0;
          end
        end
        StHeld: begin
          if (res != ScanOne) begin
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = StIdle;
            end else begin
              state_d = StReleaseWait;
              deb_d   = DebW'(1);
            end
          end
        end
        StReleaseWait: begin
          if (res == ScanOne) begin
            state_d = StHeld;
            deb_d   = '0;
          end else if (deb_inc >= DebW'(DEBOUNCE_SCANS)) begin
            state_d = StIdle;
            deb_d   = '0;
          end else begin
            deb_d = deb_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      state_q     <= StIdle;
      deb_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      deb_q       <= deb_d;
      cand_q      <= cand_d;
      key_valid_q <= key_hit;
      if (key_hit) key_code_q <= key_hit_code;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad value entry: accumulates accepted keys into entry and commits on F.
// Define KEYPAD_ENTRY_HEX_EN for hex shift-in entry instead of decimal saturating entry.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 2000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] entry,
  output logic [7:0] data,
  output logic       valid,
  output logic [3:0] key_code,
  output logic       key_valid
);

  logic       key_hit;
  logic [3:0] key_hit_code;
  logic [7:0] entry_q, entry_d, data_q, data_d;
  logic       valid_q, valid_d;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_hit     (key_hit),
    .key_hit_code(key_hit_code)
  );

`ifdef KEYPAD_ENTRY_HEX_EN
`else
  logic [11:0] dec_sum;
  assign dec_sum = {4'h0, entry_q} * 12'd10 + {8'h00, key_hit_code};
`endif

  // key_hit precedes key_valid by one cycle so the registers land with the strobe.
  always_comb begin
    entry_d = entry_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (key_hit) begin
      if (key_hit_code == KEY_CLEAR) begin
        entry_d = 8'h00;
      end else if (key_hit_code == KEY_ENTER) begin
        data_d  = entry_q;
        valid_d = 1'b1;
        entry_d = 8'h00;
      end else begin
`ifdef KEYPAD_ENTRY_HEX_EN
        entry_d = {entry_q[3:0], key_hit_code};
`else
        if (key_hit_code <= 4'd9) begin
          entry_d = (dec_sum > 12'd255) ? 8'hFF : dec_sum[7:0];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign entry = entry_q;
  assign data  = data_q;
  assign valid = valid_q;

endmodule
